// File: rtl/core_pkg.sv
// Shared core types for the load/store unit: operator and FSM state
// encodings, the default bus timeout and a store-detection helper.
package core_pkg;

    localparam int LSU_TIMEOUT_DEFAULT = 16;

    typedef enum logic [2:0] {
        LB  = 3'd0,
        LH  = 3'd1,
        LW  = 3'd2,
        LBU = 3'd3,
        LHU = 3'd4,
        SB  = 3'd5,
        SH  = 3'd6,
        SW  = 3'd7
    } lsu_op_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_RESP = 2'd2,
        DONE      = 2'd3
    } lsu_state_t;

    function automatic logic is_store(input lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic shared by the store and load paths: byte-enable
// generation, store data replication, misalignment detection, and load lane
// selection with sign/zero extension.
module lsu_align
    import core_pkg::*;
(
    input  lsu_op_t     op,
    input  logic [1:0]  addr_lsb,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane_byte;
    logic [15:0] lane_half;

    // Access size drives the enables and the alignment check; store data is replicated across lanes
    always_comb begin
        be         = 4'b0000;
        wdata      = 32'h0000_0000;
        misaligned = 1'b0;
        case (op)
            LB, LBU, SB: be = 4'b0001 << addr_lsb;
            LH, LHU, SH: begin
                be         = 4'b0011 << {addr_lsb[1], 1'b0};
                misaligned = addr_lsb[0];
            end
            default: begin
                be         = 4'hF;
                misaligned = |addr_lsb;
            end
        endcase
        case (op)
            SB:      wdata = {4{store_data[7:0]}};
            SH:      wdata = {2{store_data[15:0]}};
            SW:      wdata = store_data;
            default: wdata = 32'h0000_0000;
        endcase
    end

    // Pick the addressed lane out of the returned word and extend it to 32 bits
    always_comb begin
        lane_byte = load_raw[{addr_lsb, 3'b000} +: 8];
        lane_half = load_raw[{addr_lsb[1], 4'b0000} +: 16];
        case (op)
            LB:      load_data = {{24{lane_byte[7]}}, lane_byte};
            LBU:     load_data = {24'h000000, lane_byte};
            LH:      load_data = {{16{lane_half[15]}}, lane_half};
            LHU:     load_data = {16'h0000, lane_half};
            LW:      load_data = load_raw;
            default: load_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// Sequential load/store unit: one memory operation at a time, with an
// address-phase request/grant handshake, a response wait for loads,
// misalignment trapping and a bus timeout.
module lsu_ctrl
    import core_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = LSU_TIMEOUT_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  lsu_en_ip,
    input  lsu_op_t               lsu_operator_ip,
    input  logic                  alu_valid_ip,
    input  logic [ADDR_WIDTH-1:0] mem_addr_ip,
    input  logic [31:0]           store_data_ip,
    output logic                  data_req_op,
    input  logic                  data_gnt_i,
    output logic [ADDR_WIDTH-1:0] data_addr_op,
    output logic                  data_we_op,
    output logic [3:0]            data_be_op,
    output logic [31:0]           data_wdata_op,
    input  logic                  data_rvalid_i,
    input  logic [31:0]           mem_data_ip,
    output logic                  lsu_valid_op,
    output logic [31:0]           load_mem_data_op,
    output logic                  lsu_busy_op,
    output logic                  misaligned_op,
    output logic                  bus_err_op
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t            state_q, state_d;
    lsu_op_t               op_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [3:0]            be_q;
    logic [31:0]           wdata_q;
    logic [31:0]           result_q;
    logic                  mis_q;
    logic                  err_q;
    logic [CNT_W-1:0]      cnt_q;

    lsu_op_t               align_op;
    logic [1:0]            align_lsb;
    logic [3:0]            align_be;
    logic [31:0]           align_wdata;
    logic [31:0]           align_load;
    logic                  align_mis;
    logic                  accept;
    logic                  timed_out;

    // While idle the aligner sees the incoming op; afterwards it sees the captured one
    assign align_op  = (state_q == IDLE) ? lsu_operator_ip : op_q;
    assign align_lsb = (state_q == IDLE) ? mem_addr_ip[1:0] : addr_q[1:0];
    assign accept    = lsu_en_ip & alu_valid_ip;
    assign timed_out = (cnt_q == CNT_LAST);

    lsu_align u_align (
        .op         (align_op),
        .addr_lsb   (align_lsb),
        .store_data (store_data_ip),
        .load_raw   (mem_data_ip),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misaligned (align_mis)
    );

    // State register
    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state selection and bus/completion outputs, only driven in the owning state
    always_comb begin
        state_d          = state_q;
        data_req_op      = 1'b0;
        data_addr_op     = '0;
        data_we_op       = 1'b0;
        data_be_op       = 4'b0000;
        data_wdata_op    = 32'h0000_0000;
        lsu_valid_op     = 1'b0;
        load_mem_data_op = 32'h0000_0000;
        misaligned_op    = 1'b0;
        bus_err_op       = 1'b0;
        lsu_busy_op      = (state_q != IDLE);
        case (state_q)
            IDLE: begin
                if (accept) state_d = align_mis ? DONE : REQ;
            end
            REQ: begin
                data_req_op   = 1'b1;
                data_addr_op  = {addr_q[ADDR_WIDTH-1:2], 2'b00};
                data_we_op    = is_store(op_q);
                data_be_op    = be_q;
                data_wdata_op = wdata_q;
                if (data_gnt_i)     state_d = is_store(op_q) ? DONE : WAIT_RESP;
                else if (timed_out) state_d = DONE;
            end
            WAIT_RESP: begin
                if (data_rvalid_i || timed_out) state_d = DONE;
            end
            DONE: begin
                lsu_valid_op     = 1'b1;
                load_mem_data_op = result_q;
                misaligned_op    = mis_q;
                bus_err_op       = err_q;
                state_d          = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Capture the operation on accept, run the timeout counter and record the completion status
    always_ff @(posedge clock) begin
        if (reset) begin
            op_q     <= LB;
            addr_q   <= '0;
            be_q     <= 4'b0000;
            wdata_q  <= 32'h0000_0000;
            result_q <= 32'h0000_0000;
            mis_q    <= 1'b0;
            err_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q     <= lsu_operator_ip;
                        addr_q   <= mem_addr_ip;
                        be_q     <= align_be;
                        wdata_q  <= align_wdata;
                        mis_q    <= align_mis;
                        err_q    <= 1'b0;
                        result_q <= 32'h0000_0000;
                        cnt_q    <= '0;
                    end
                end
                REQ: begin
                    if (data_gnt_i) begin
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (timed_out) err_q <= 1'b1;
                    end
                end
                WAIT_RESP: begin
                    if (data_rvalid_i) begin
                        result_q <= align_load;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                        if (timed_out) err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed cases plus randomized operations
// checked against a size/offset arithmetic model of the load/store rules.
module tb_lsu_ctrl;
    import core_pkg::*;

    localparam int AW = 32;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          lsu_en_ip;
    lsu_op_t       lsu_operator_ip;
    logic          alu_valid_ip;
    logic [AW-1:0] mem_addr_ip;
    logic [31:0]   store_data_ip;
    logic          data_req_op;
    logic          data_gnt_i;
    logic [AW-1:0] data_addr_op;
    logic          data_we_op;
    logic [3:0]    data_be_op;
    logic [31:0]   data_wdata_op;
    logic          data_rvalid_i;
    logic [31:0]   mem_data_ip;
    logic          lsu_valid_op;
    logic [31:0]   load_mem_data_op;
    logic          lsu_busy_op;
    logic          misaligned_op;
    logic          bus_err_op;

    int errCount   = 0;
    int checkCount = 0;

    always #5 clock = ~clock;

    lsu_ctrl #(.ADDR_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
        .clock            (clock),
        .reset            (reset),
        .lsu_en_ip        (lsu_en_ip),
        .lsu_operator_ip  (lsu_operator_ip),
        .alu_valid_ip     (alu_valid_ip),
        .mem_addr_ip      (mem_addr_ip),
        .store_data_ip    (store_data_ip),
        .data_req_op      (data_req_op),
        .data_gnt_i       (data_gnt_i),
        .data_addr_op     (data_addr_op),
        .data_we_op       (data_we_op),
        .data_be_op       (data_be_op),
        .data_wdata_op    (data_wdata_op),
        .data_rvalid_i    (data_rvalid_i),
        .mem_data_ip      (mem_data_ip),
        .lsu_valid_op     (lsu_valid_op),
        .load_mem_data_op (load_mem_data_op),
        .lsu_busy_op      (lsu_busy_op),
        .misaligned_op    (misaligned_op),
        .bus_err_op       (bus_err_op)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errCount++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    function automatic int opSize(input lsu_op_t op);
        if (op == LB || op == LBU || op == SB) return 1;
        if (op == LH || op == LHU || op == SH) return 2;
        return 4;
    endfunction

    function automatic bit opStore(input lsu_op_t op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    function automatic bit expMis(input lsu_op_t op, input logic [31:0] addr);
        int off = int'(addr[1:0]);
        return (off % opSize(op)) != 0;
    endfunction

    function automatic logic [3:0] expBe(input lsu_op_t op, input logic [31:0] addr);
        int off = int'(addr[1:0]);
        int mask = (1 << opSize(op)) - 1;
        return 4'(mask << off);
    endfunction

    function automatic logic [31:0] expWdata(input lsu_op_t op, input logic [31:0] d);
        if (op == SB) return 32'(d[7:0]) * 32'h0101_0101;
        if (op == SH) return 32'(d[15:0]) * 32'h0001_0001;
        if (op == SW) return d;
        return 32'h0;
    endfunction

    function automatic logic [31:0] expLoad(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] raw);
        int          off  = int'(addr[1:0]);
        int          bits = 8 * opSize(op);
        logic [31:0] v    = raw >> (8 * off);
        logic [31:0] mask;
        if (bits == 32) return v;
        mask = (32'h1 << bits) - 32'h1;
        v = v & mask;
        if ((op == LB || op == LH) && v[bits-1]) v = v | ~mask;
        return v;
    endfunction

    task automatic driveNoise(input bit noise);
        if (noise) begin
            lsu_en_ip       = 1'($urandom);
            alu_valid_ip    = 1'($urandom);
            lsu_operator_ip = lsu_op_t'(3'($urandom_range(0, 7)));
            mem_addr_ip     = $urandom;
            store_data_ip   = $urandom;
        end else begin
            lsu_en_ip    = 1'b0;
            alu_valid_ip = 1'b0;
        end
    endtask

    // One full operation: accept, handshake as the memory, check bus and completion
    task automatic applyStimulus(input lsu_op_t op, input logic [31:0] addr, input logic [31:0] sdata,
                                 input logic [31:0] rdata, input int gntDelay, input int rvDelay,
                                 input bit noise);
        bit gotGnt = 0;
        bit gotRv  = 0;
        checkOutput("idle.busy", 32'(lsu_busy_op), 32'h0);
        lsu_en_ip       = 1'b1;
        alu_valid_ip    = 1'b1;
        lsu_operator_ip = op;
        mem_addr_ip     = addr;
        store_data_ip   = sdata;
        tick();
        if (expMis(op, addr)) begin
            driveNoise(0);
            checkOutput("mis.valid", 32'(lsu_valid_op), 32'h1);
            checkOutput("mis.flag", 32'(misaligned_op), 32'h1);
            checkOutput("mis.req", 32'(data_req_op), 32'h0);
            checkOutput("mis.err", 32'(bus_err_op), 32'h0);
            tick();
            checkOutput("mis.after.valid", 32'(lsu_valid_op), 32'h0);
            checkOutput("mis.after.busy", 32'(lsu_busy_op), 32'h0);
            return;
        end
        for (int k = 0; k < TO; k++) begin
            driveNoise(noise);
            checkOutput("req.req", 32'(data_req_op), 32'h1);
            checkOutput("req.addr", data_addr_op, addr & 32'hFFFF_FFFC);
            checkOutput("req.we", 32'(data_we_op), 32'(opStore(op)));
            checkOutput("req.be", 32'(data_be_op), 32'(expBe(op, addr)));
            checkOutput("req.wdata", data_wdata_op, expWdata(op, sdata));
            checkOutput("req.valid", 32'(lsu_valid_op), 32'h0);
            data_rvalid_i = noise ? 1'($urandom) : 1'b0;
            mem_data_ip   = $urandom;
            if (k == gntDelay) begin
                data_gnt_i = 1'b1;
                gotGnt     = 1;
            end
            tick();
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            if (gotGnt) break;
        end
        if (gotGnt && !opStore(op)) begin
            for (int j = 0; j < TO; j++) begin
                driveNoise(noise);
                checkOutput("wait.valid", 32'(lsu_valid_op), 32'h0);
                checkOutput("wait.req", 32'(data_req_op), 32'h0);
                checkOutput("wait.busy", 32'(lsu_busy_op), 32'h1);
                data_gnt_i  = noise ? 1'($urandom) : 1'b0;
                mem_data_ip = $urandom;
                if (j == rvDelay) begin
                    data_rvalid_i = 1'b1;
                    mem_data_ip   = rdata;
                    gotRv         = 1;
                end
                tick();
                data_gnt_i    = 1'b0;
                data_rvalid_i = 1'b0;
                if (gotRv) break;
            end
        end
        driveNoise(0);
        checkOutput("done.valid", 32'(lsu_valid_op), 32'h1);
        checkOutput("done.mis", 32'(misaligned_op), 32'h0);
        if (!gotGnt) begin
            checkOutput("done.err", 32'(bus_err_op), 32'h1);
            checkOutput("done.data", load_mem_data_op, 32'h0);
        end else if (opStore(op)) begin
            checkOutput("done.err", 32'(bus_err_op), 32'h0);
        end else begin
            checkOutput("done.err", 32'(bus_err_op), 32'(!gotRv));
            checkOutput("done.data", load_mem_data_op, gotRv ? expLoad(op, addr, rdata) : 32'h0);
        end
        tick();
        checkOutput("after.valid", 32'(lsu_valid_op), 32'h0);
        checkOutput("after.busy", 32'(lsu_busy_op), 32'h0);
    endtask

    // Every output must read zero when the unit is idle after reset
    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".outs"},
                    32'({data_req_op, data_we_op, data_be_op, lsu_valid_op, lsu_busy_op, misaligned_op, bus_err_op}),
                    32'h0);
        checkOutput({tag, ".addr"}, data_addr_op, 32'h0);
        checkOutput({tag, ".wdata"}, data_wdata_op, 32'h0);
        checkOutput({tag, ".data"}, load_mem_data_op, 32'h0);
    endtask

    initial begin
        int gd;
        int rd;
        lsu_op_t rop;
        reset           = 1'b1;
        lsu_en_ip       = 1'b0;
        alu_valid_ip    = 1'b0;
        lsu_operator_ip = LB;
        mem_addr_ip     = '0;
        store_data_ip   = '0;
        data_gnt_i      = 1'b0;
        data_rvalid_i   = 1'b0;
        mem_data_ip     = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        checkAllZero("reset");

        applyStimulus(SB,  32'h0000_1003, 32'h0000_00A5, 32'h0, 0, 0, 0);
        applyStimulus(LB,  32'h0000_2001, 32'h0, 32'h0000_8000, 0, 2, 0);
        applyStimulus(LBU, 32'h0000_2001, 32'h0, 32'h0000_8000, 0, 2, 0);
        applyStimulus(LW,  32'h0000_3002, 32'h0, 32'h0, 0, 0, 0);
        applyStimulus(SH,  32'h0000_4002, 32'h1234_BEEF, 32'h0, 4, 0, 0);
        applyStimulus(LW,  32'h0000_5000, 32'h0, 32'h0, 99, 0, 0);
        applyStimulus(LW,  32'h0000_5004, 32'h0, 32'hCAFE_F00D, 0, 0, 0);
        applyStimulus(LH,  32'h0000_6002, 32'h0, 32'h8001_7FFF, 1, 99, 0);
        applyStimulus(LHU, 32'h0000_6002, 32'h0, 32'h8001_7FFF, 0, 15, 0);
        applyStimulus(SW,  32'h0000_7000, 32'hDEAD_BEEF, 32'h0, 15, 0, 0);

        for (int n = 0; n < 150; n++) begin
            rop = lsu_op_t'(3'($urandom_range(0, 7)));
            gd  = ($urandom_range(0, 19) == 0) ? 16 + $urandom_range(0, 4) : $urandom_range(0, 3);
            rd  = ($urandom_range(0, 19) == 0) ? 16 + $urandom_range(0, 4) : $urandom_range(0, 3);
            applyStimulus(rop, $urandom, $urandom, $urandom, gd, rd, 1'($urandom));
        end

        lsu_en_ip       = 1'b1;
        alu_valid_ip    = 1'b1;
        lsu_operator_ip = LW;
        mem_addr_ip     = 32'h0000_8000;
        tick();
        driveNoise(0);
        data_gnt_i = 1'b1;
        tick();
        data_gnt_i = 1'b0;
        checkOutput("rst.wait.busy", 32'(lsu_busy_op), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checkAllZero("rst.mid");
        data_rvalid_i = 1'b1;
        mem_data_ip   = 32'h1234_5678;
        tick();
        data_rvalid_i = 1'b0;
        checkAllZero("rst.stale");
        tick();
        checkAllZero("rst.stale2");

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
